// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants and FSM state type for the SPI flash burst reader
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int ADDR_BITS = 24;
  localparam int DUMMY_BITS = 8;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, CSHOLD} state_t;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: mode-0 SCK divider with rise/fall strobes; hold freezes the divider mid-phase
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic spi_sck,
  output logic rise,
  output logic fall
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = !clr && !hold && cnt == CW'(CLK_DIV - 1);
  assign rise = tick && !spi_sck;
  assign fall = tick && spi_sck;
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      spi_sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      spi_sck <= !spi_sck;
    end else if (!hold)
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI flash burst reader streaming bytes over valid/ready with SCK stall on backpressure
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LEN_W = 16,
  parameter int FAST_READ = 0,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             spi_cs_n,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  localparam logic [7:0] CMD_BYTE = FAST_READ != 0 ? CMD_FAST_READ : CMD_READ;
  state_t state, state_nx;
  logic rise, fall, stall, sck_clr, go, last_bit, byte_done;
  logic [4:0] bcnt;
  logic [LEN_W-1:0] lcnt;
  logic [31:0] tx;
  logic [6:0] rx;
  logic [15:0] hcnt;
  assign busy = state != IDLE;
  assign spi_mosi = tx[31];
  assign go = state == IDLE && start && len != '0;
  assign sck_clr = state == IDLE || state == CSHOLD;
  assign last_bit = bcnt == (state == ADDR ? 5'(ADDR_BITS - 1) : state == DUMMY ? 5'(DUMMY_BITS - 1) : 5'd7);
  assign byte_done = rise && state == DATA && last_bit;
  // Withhold only the rising edge of a byte's last bit so a pending byte is never overwritten
  assign stall = state == DATA && last_bit && !spi_sck && out_valid && !out_ready;
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk(clk), .rst(rst), .clr(sck_clr), .hold(stall),
    .spi_sck(spi_sck), .rise(rise), .fall(fall)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? CMD : IDLE;
      CMD:     state_nx = fall && last_bit ? ADDR : CMD;
      ADDR:    state_nx = fall && last_bit ? (FAST_READ != 0 ? DUMMY : DATA) : ADDR;
      DUMMY:   state_nx = fall && last_bit ? DATA : DUMMY;
      DATA:    state_nx = fall && last_bit && lcnt == LEN_W'(1) ? CSHOLD : DATA;
      CSHOLD:  state_nx = spi_cs_n && hcnt == 16'(CS_HIGH_MIN - 1) ? IDLE : CSHOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      spi_cs_n <= 1'b1;
      done <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      bcnt <= '0;
      lcnt <= '0;
      tx <= '0;
      rx <= '0;
      hcnt <= '0;
    end else begin
      done <= 1'b0;
      if (go) begin
        spi_cs_n <= 1'b0;
        tx <= {CMD_BYTE, addr};
        lcnt <= len;
        bcnt <= '0;
      end
      if (state == IDLE && start && len == '0) done <= 1'b1;
      if (fall) begin
        bcnt <= last_bit ? '0 : bcnt + 1'b1;
        tx <= {tx[30:0], 1'b0};
      end
      if (fall && state == DATA && last_bit) lcnt <= lcnt - 1'b1;
      if (rise && state == DATA) rx <= {rx[5:0], spi_miso};
      if (byte_done) out_data <= {rx, spi_miso};
      out_valid <= byte_done || (out_valid && !out_ready);
      // CSHOLD first waits out the CS tail with CS low, then the minimum CS-high time
      if (state != CSHOLD) hcnt <= '0;
      else if (!spi_cs_n && hcnt == 16'(CLK_DIV - 1)) begin
        spi_cs_n <= 1'b1;
        done <= 1'b1;
        hcnt <= '0;
      end else hcnt <= hcnt + 1'b1;
    end
endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Parametrised SPI-flash burst reader and successor to the fixed 8192-bit frame loader.
- Starts on a start/busy/done handshake with a run-time address and byte length, and supports a programmable SCK divider and an optional FAST_READ mode with dummy cycles.
- Streams bytes out through a valid/ready port and stalls SCK under backpressure, so no frame-wide shift register is needed.
- Sits between the external flash pins and the frame buffer / display-matrix loader.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles, >=1; one SCK bit = 2*CLK_DIV clk cycles.
- LEN_W, 16: width of the byte-length input.
- FAST_READ, 0: 0 = command 0x03 with no dummy; 1 = command 0x0B followed by 8 dummy SCK cycles.
- CS_HIGH_MIN, 4: minimum CS_n high time between bursts, in clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only while busy=0
- addr  in  24  flash byte address, latched on an accepted start
- len  in  LEN_W  byte count, latched on an accepted start
- busy  out  1  high from the cycle after an accepted start until the CS_HIGH_MIN hold ends
- done  out  1  one-cycle pulse at burst completion
- out_data  out  8  received byte, MSB received first
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the byte when out_valid & out_ready
- spi_cs_n  out  1  flash chip select, active low
- spi_sck  out  1  SPI mode 0 clock, idle low
- spi_mosi  out  1  command/address bits
- spi_miso  in  1  flash data

Behaviour:
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, busy=0, done=0, out_valid=0, out_data=0, state=IDLE.
- Reset mid-burst aborts on that edge. The pending byte is dropped and no done pulse is generated.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> [DUMMY (8 bits) if FAST_READ] -> DATA (8*len bits) -> CSHOLD -> IDLE.
- IDLE:
  - start=1 with len!=0: latch addr/len, drive spi_cs_n=0 and the command MSB on spi_mosi in the same edge, enter CMD.
  - start=1 with len==0: no CS activity, done pulses the next cycle, busy stays 0.
  - start while busy=1 is ignored.
- SCK timing, mode 0:
  - After CS_n falls, wait CLK_DIV cycles, then SCK rises.
  - MISO is sampled on the rising edge.
  - SCK falls CLK_DIV cycles later; MOSI shifts to the next bit on that same edge.
- MOSI order: command MSB-first, then address[23:0] MSB-first. MOSI is 0 during DUMMY and DATA.
- DATA: bits are assembled MSB-first into a shift register. After the 8th sampled bit, the byte moves to out_data and out_valid is set.
- Backpressure: the rising edge for a byte's 8th bit is withheld while out_valid=1 && out_ready=0.
  - SCK stays low and the divider holds.
  - No byte is ever lost or overwritten.
- out_valid clears on handshake. If a new byte completes in the same cycle as a handshake, out_valid stays 1 with the new data.
- End of burst:
  - After the final bit's falling edge, wait CLK_DIV cycles, then raise spi_cs_n.
  - done pulses in the cycle spi_cs_n returns to 1. The last byte may still be pending on out_valid.
  - busy deasserts after CS_HIGH_MIN further cycles.
- Total clk cycles from start to CS_n rise with no stall: 1 + 2*CLK_DIV*(32 + 8*FAST_READ + 8*len) + CLK_DIV.
- Address arithmetic: counting is done in the flash. The block holds CS low for the whole burst and never re-issues the address; wrap at the end of flash is the flash's behaviour.
- Length counter is LEN_W bits and counts remaining bytes down to 0.

Decomposition:
- Package spi_flash_pkg:
  - CMD_READ = 8'h03, CMD_FAST_READ = 8'h0B
  - ADDR_BITS = 24, DUMMY_BITS = 8
  - state enum IDLE/CMD/ADDR/DUMMY/DATA/CSHOLD
- Sub-module spi_sck_gen: divider counter producing rise/fall strobes and spi_sck, with a hold input for stall and idle.
- spi_flash_reader holds the FSM, bit/byte counters, MOSI shifter, MISO shifter and output register.

Test Plan:
- CLK_DIV=2, FAST_READ=0, addr=0x012345, len=2, out_ready=1, flash model returns 0xA5, 0x3C:
  - MOSI captures 0x03 then 0x012345.
  - Out bytes are 0xA5, 0x3C.
  - done occurs exactly 1+4*48+2 = 195 cycles after start.
  - 48 SCK rising edges.
- FAST_READ=1, len=1: 40 command/address/dummy edges precede data; the byte matches model data at the address.
- len=4, out_ready held 0 for 50 cycles after the first byte:
  - SCK stays low during the stall.
  - All 4 bytes arrive in order; no duplicates, none dropped.
- len=0 start: spi_cs_n never falls; done pulses the next cycle; busy stays 0.
- Assert rst mid-DATA (after 12 data bits):
  - Next cycle spi_cs_n=1, spi_sck=0, out_valid=0, no done pulse.
  - A fresh start then completes normally.
- start pulsed during an active burst and during CSHOLD: ignored. CS_n high for >= CS_HIGH_MIN cycles between back-to-back bursts.
